async_receiver_scard: RTL and testbench
=======================================

Name: async_receiver_scard

Overview:
- ISO7816-style character receiver for the smartcard I/O line.
- Frame: start (0), 8 data bits LSB-first, even-parity bit (XOR of data), 2 stop bits (1).
- Oversamples the line, checks parity and stop, and presents each byte with error flags.
- On a parity error it can request an error-signal (NACK) pulse on the shared open-drain line; the top level ANDs `RxD_nack` low onto the pad.

Parameters:
- ClkFrequency, 40000000 (`UART_CLK): system clock in Hz.
- Baud, 9600: line bit rate in bit/s (1 etu = 1/Baud).
- Oversampling, 16: baud ticks per etu (power of 2, at least 8).
- BaudGeneratorAccWidth, 16: fractional accumulator width.
- NackOnError, 1: 1 means drive the NACK pulse on parity error; 0 means never drive it.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- RxD  input  1  raw smartcard I/O line; idles high.
- RxD_data  output  8  last received byte.
- RxD_data_ready  output  1  one-clk pulse when a frame completes.
- RxD_parity_error  output  1  one-clk pulse, coincident with RxD_data_ready, when parity fails.
- RxD_framing_error  output  1  one-clk pulse, coincident with RxD_data_ready, when stop1 is sampled low.
- RxD_nack  output  1  1 = pull the I/O line low (error signal).
- RxD_busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- **Reset** (async, rst=1): all state cleared. RxD_data=0x00; ready, parity_error, framing_error, nack and busy all 0; FSM in IDLE.
- **Reset mid-frame:** aborts the frame; no ready pulse is ever produced for the partial byte.

- **Input synchronizer:** 2-flop synchronizer on RxD, reset to 1. All sampling uses the synchronized value. This adds 2 clk of latency.

- **Tick generator:**
  - Accumulator is (W+1) bits, W = BaudGeneratorAccWidth.
  - Each clk, acc <= acc[W-1:0] + Inc, with Inc = round(Baud*Oversampling*2^W / ClkFrequency). Inc = 252 for the defaults.
  - tick = acc[W].
  - Accumulator is held at 0 in IDLE, so it is restarted on start-edge detection.

- **Sampling:**
  - cnt counts ticks within an etu, 0..Oversampling-1.
  - Bit value = majority of the samples at ticks Oversampling/2-1, /2 and /2+1.
  - Decision is made at tick Oversampling/2+1.

- **FSM states:**
  - IDLE:
    - Synchronized RxD=0 → START; cnt=0; busy=1.
  - START:
    - At the decision tick, majority=1 → IDLE (glitch rejected, no outputs).
    - At the decision tick, majority=0 → continue in START.
    - At cnt wrap → DATA, bit index 0.
  - DATA:
    - Shift the decided bit into shreg[7] (LSB-first, right shift).
    - Advance the index at each etu wrap; after bit 7 → PARITY.
  - PARITY:
    - Decided bit p.
    - perr = p ^ (^shreg).
    - At wrap → STOP.
  - STOP:
    - At the decision tick (10.5 etu from the start edge):
      - RxD_data <= shreg.
      - Pulse ready for one clk, with perr and ferr=(bit==0).
    - Next state:
      - perr and NackOnError → NACK.
      - Otherwise → WAITHIGH.
  - NACK:
    - RxD_nack=1 for exactly Oversampling ticks (1 etu), from the clk after the ready pulse.
    - Then → WAITHIGH.
  - WAITHIGH:
    - Synchronized RxD must be 1 for Oversampling/2 consecutive ticks → IDLE; busy=0.
    - A low restarts that count.
    - This covers the second stop bit and the card's own guard/NACK.

- **Data stability:** RxD_data changes only at a ready pulse and holds otherwise.
- **Flag exclusivity:** error flags are 0 whenever ready is 0.
- **Simultaneous errors:** parity and framing errors may both pulse in the same frame.
- **Back-to-back frames:** a start edge arriving directly after the WAITHIGH condition is met is accepted. Minimum frame spacing is 11 etu.

Test Plan:
1. **Good byte.** Send 0xA5 (parity 0, 2 stop bits) at default parameters → exactly one ready pulse ~10.5 etu after the start edge; RxD_data=0xA5; both error flags 0; nack stays 0; busy falls before the next frame.
2. **Parity error.** Send 0x3C with parity=1 → ready pulse with RxD_data=0x3C and parity_error=1; then nack=1 for 16 ticks (~4167 clk ±1 tick); back to IDLE after the line has been high for 8 ticks.
3. **Parity error, NACK disabled.** Same frame as 2 with NackOnError=0 → parity_error=1; nack never asserts.
4. **Framing error.** Send 0x01 with stop1=0, then the line returns high → ready with framing_error=1 and parity_error=0; RxD_data=0x01.
5. **Glitch rejection.** A 2-tick low glitch on the idle line → no ready pulse, busy falls after the START decision tick. Then 0xFF, 0x00, 0x80 back-to-back → three ready pulses with the correct data and no errors.
6. **Reset mid-frame.** Assert rst at data bit 4 of 0x55 → all outputs 0 immediately and no ready pulse. Then a subsequent 0x55 frame → received correctly.

Source files
------------

// File: rtl/async_receiver_scard.sv
// ISO7816-style character receiver for the smartcard I/O line.
// Frame: start(0), 8 data bits LSB-first, even parity, 2 stop bits(1).
// The line is oversampled; each bit is the majority of three mid-etu
// samples. Parity and stop-bit errors are flagged with the byte, and a
// parity error can request a one-etu NACK pulse on the open-drain line.
//
// Ports:
//   clk               system clock
//   rst               asynchronous active-high reset
//   RxD               raw smartcard I/O line (idles high)
//   RxD_data          last received byte (changes only with RxD_data_ready)
//   RxD_data_ready    one-clk pulse when a frame completes
//   RxD_parity_error  one-clk pulse with RxD_data_ready on parity failure
//   RxD_framing_error one-clk pulse with RxD_data_ready when stop1 is low
//   RxD_nack          1 = pull the I/O line low (error signal)
//   RxD_busy          high from start-bit detection until back in IDLE
module async_receiver_scard #(
   parameter int unsigned ClkFrequency          = 40000000,
   parameter int unsigned Baud                  = 9600,
   parameter int unsigned Oversampling          = 16,
   parameter int unsigned BaudGeneratorAccWidth = 16,
   parameter int unsigned NackOnError           = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RxD,
   output logic [7:0] RxD_data,
   output logic       RxD_data_ready,
   output logic       RxD_parity_error,
   output logic       RxD_framing_error,
   output logic       RxD_nack,
   output logic       RxD_busy
);

   localparam int unsigned W    = BaudGeneratorAccWidth;
   localparam int unsigned CntW = $clog2(Oversampling);

   // Rounded fractional increment; computed in 64 bits to avoid overflow.
   localparam longint unsigned IncL =
      ((64'(Baud) * 64'(Oversampling) << W) + 64'(ClkFrequency) / 2) / 64'(ClkFrequency);
   localparam logic [W:0] Inc = IncL[W:0];

   localparam logic [CntW-1:0] CntMax   = CntW'(Oversampling - 1);
   localparam logic [CntW-1:0] SampA    = CntW'(Oversampling / 2 - 1);
   localparam logic [CntW-1:0] SampB    = CntW'(Oversampling / 2);
   localparam logic [CntW-1:0] SampC    = CntW'(Oversampling / 2 + 1);
   localparam logic [CntW-1:0] HighDone = CntW'(Oversampling / 2 - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, NACK, WAITHIGH
   } state_t;

   state_t          state, state_nxt;
   logic            sync1, rx_s;
   logic [W:0]      acc;
   logic            tick;
   logic [CntW-1:0] cnt;
   logic [2:0]      idx;
   logic            samp0, samp1;
   logic [7:0]      shreg;
   logic            perr_r;
   logic            decide, wrap, maj;

   assign tick   = acc[W];
   assign decide = tick && (cnt == SampC);
   assign wrap   = tick && (cnt == CntMax);
   // Third sample is the live synchronized value at the decision tick.
   assign maj    = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

   assign RxD_busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (!rx_s) state_nxt = START;
         START: begin
            if (decide && maj) state_nxt = IDLE;
            else if (wrap)     state_nxt = DATA;
         end
         DATA:     if (wrap && idx == 3'd7) state_nxt = PARITY;
         PARITY:   if (wrap) state_nxt = STOP;
         STOP: begin
            if (decide)
               state_nxt = (perr_r && NackOnError != 0) ? NACK : WAITHIGH;
         end
         NACK:     if (wrap) state_nxt = WAITHIGH;
         WAITHIGH: if (rx_s && tick && cnt == HighDone) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1             <= 1'b1;
         rx_s              <= 1'b1;
         acc               <= '0;
         cnt               <= '0;
         idx               <= '0;
         samp0             <= 1'b0;
         samp1             <= 1'b0;
         shreg             <= '0;
         perr_r            <= 1'b0;
         RxD_data          <= '0;
         RxD_data_ready    <= 1'b0;
         RxD_parity_error  <= 1'b0;
         RxD_framing_error <= 1'b0;
         RxD_nack          <= 1'b0;
      end else begin
         sync1 <= RxD;
         rx_s  <= sync1;

         // Held at zero while idle so the etu phase starts at the start edge.
         if (state == IDLE) acc <= '0;
         else               acc <= {1'b0, acc[W-1:0]} + Inc;

         RxD_data_ready    <= 1'b0;
         RxD_parity_error  <= 1'b0;
         RxD_framing_error <= 1'b0;
         RxD_nack          <= (state == NACK);

         if (tick) begin
            if (cnt == SampA) samp0 <= rx_s;
            if (cnt == SampB) samp1 <= rx_s;
         end

         // cnt wraps naturally at etu boundaries; NACK and WAITHIGH
         // reuse it and so restart it when leaving STOP.
         case (state)
            IDLE:     cnt <= '0;
            STOP: begin
               if (decide)    cnt <= '0;
               else if (tick) cnt <= cnt + 1'b1;
            end
            WAITHIGH: begin
               if (!rx_s)     cnt <= '0;
               else if (tick) cnt <= cnt + 1'b1;
            end
            default:  if (tick) cnt <= cnt + 1'b1;
         endcase

         if (state == START)             idx <= '0;
         else if (state == DATA && wrap) idx <= idx + 1'b1;

         if (state == DATA && decide)
            shreg <= {maj, shreg[7:1]};

         if (state == PARITY && decide)
            perr_r <= maj ^ (^shreg);

         if (state == STOP && decide) begin
            RxD_data          <= shreg;
            RxD_data_ready    <= 1'b1;
            RxD_parity_error  <= perr_r;
            RxD_framing_error <= ~maj;
         end
      end
   end

endmodule

// File: tb/tb_async_receiver_scard.sv
// Bench for async_receiver_scard: two instances share one line, one with
// NACK enabled and one with it disabled. Expected bytes/flags are queued
// as frames are driven and popped when each instance pulses ready.
module tb_async_receiver_scard;

   // Clock chosen so one baud tick is exactly 8 clk and one etu 128 clk.
   localparam int unsigned ClkHz  = 1228800;
   localparam int unsigned BaudHz = 9600;
   localparam int          Etu    = 128;
   localparam int unsigned LatMin = 1344 - 8;   // ~10.5 etu after start edge
   localparam int unsigned LatMax = 1344 + 32;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic [7:0] data_a, data_b;
   logic       ready_a, ready_b, perr_a, perr_b, ferr_a, ferr_b;
   logic       nack_a, nack_b, busy_a, busy_b;

   always #5 clk = ~clk;

   async_receiver_scard #(
      .ClkFrequency(ClkHz), .Baud(BaudHz), .Oversampling(16),
      .BaudGeneratorAccWidth(16), .NackOnError(1)
   ) dut_a (
      .clk(clk), .rst(rst), .RxD(rxd), .RxD_data(data_a),
      .RxD_data_ready(ready_a), .RxD_parity_error(perr_a),
      .RxD_framing_error(ferr_a), .RxD_nack(nack_a), .RxD_busy(busy_a)
   );

   async_receiver_scard #(
      .ClkFrequency(ClkHz), .Baud(BaudHz), .Oversampling(16),
      .BaudGeneratorAccWidth(16), .NackOnError(0)
   ) dut_b (
      .clk(clk), .rst(rst), .RxD(rxd), .RxD_data(data_b),
      .RxD_data_ready(ready_b), .RxD_parity_error(perr_b),
      .RxD_framing_error(ferr_b), .RxD_nack(nack_b), .RxD_busy(busy_b)
   );

   typedef struct {
      logic [7:0]  data;
      logic        perr;
      logic        ferr;
      int unsigned t0;
   } exp_t;

   exp_t        sb_a[$];
   exp_t        sb_b[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned nack_a_cycles = 0;
   int unsigned nack_b_cycles = 0;
   bit          nack_chk = 1'b0;
   logic        nack_exp = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard side for the NACK-enabled instance.
   always @(negedge clk) begin
      exp_t        e;
      int unsigned lat;
      if (rst) begin
         nack_chk = 1'b0;
      end else begin
         if (nack_chk) begin
            check("nack_starts_after_ready", nack_a, nack_exp);
            nack_chk = 1'b0;
         end
         if (nack_a) nack_a_cycles++;
         if (ready_a) begin
            if (sb_a.size() == 0) begin
               check("ready_a_unexpected", 1, 0);
            end else begin
               e   = sb_a.pop_front();
               lat = cyc - e.t0;
               check("a_data", data_a, e.data);
               check("a_parity_error", perr_a, e.perr);
               check("a_framing_error", ferr_a, e.ferr);
               if (lat < LatMin || lat > LatMax)
                  $display("  ready latency was %0d clk", lat);
               check("a_ready_latency_in_window", (lat >= LatMin && lat <= LatMax), 1);
               nack_exp = e.perr;
               nack_chk = 1'b1;
            end
         end else if (perr_a || ferr_a) begin
            check("a_flags_without_ready", {perr_a, ferr_a}, 0);
         end
      end
   end

   // Scoreboard side for the NACK-disabled instance.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (nack_b) nack_b_cycles++;
         if (ready_b) begin
            if (sb_b.size() == 0) begin
               check("ready_b_unexpected", 1, 0);
            end else begin
               e = sb_b.pop_front();
               check("b_data", data_b, e.data);
               check("b_parity_error", perr_b, e.perr);
               check("b_framing_error", ferr_b, e.ferr);
            end
         end else if (perr_b || ferr_b) begin
            check("b_flags_without_ready", {perr_b, ferr_b}, 0);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives len clk of the frame {stop2, stop1, par, d, start}; when
   // queue_it is set the expected result is pushed for both instances.
   task automatic send(input logic [7:0] d, input logic par, input logic stop1,
                       input int len, input bit queue_it);
      logic [11:0] fr;
      exp_t        e;
      fr = {1'b1, stop1, par, d, 1'b0};
      step(1);
      if (queue_it) begin
         e.data = d;
         e.perr = par ^ (^d);
         e.ferr = ~stop1;
         e.t0   = cyc;
         sb_a.push_back(e);
         sb_b.push_back(e);
      end
      for (int i = 0; i < len; i++) begin
         rxd = fr[i / Etu];
         step(1);
      end
      rxd = 1'b1;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      @(negedge clk);
      while ((busy_a || busy_b) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(tag, {busy_a, busy_b}, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned g0;
      rst = 1'b1;
      rxd = 1'b1;
      step(3);
      check("reset_data", data_a, 8'h00);
      check("reset_ready", ready_a, 0);
      check("reset_flags", {perr_a, ferr_a}, 0);
      check("reset_nack", nack_a, 0);
      check("reset_busy", busy_a, 0);
      rst = 1'b0;
      step(2 * Etu);

      // Good byte.
      nack_a_cycles = 0;
      send(8'hA5, 1'b0, 1'b1, 12 * Etu, 1'b1);
      wait_idle("good_idle", 4 * Etu);
      check("good_data_hold", data_a, 8'hA5);
      check("good_no_nack", nack_a_cycles, 0);
      step(2 * Etu);

      // Parity error: NACK for 16 ticks on A, never on B.
      nack_a_cycles = 0;
      send(8'h3C, 1'b1, 1'b1, 12 * Etu, 1'b1);
      wait_idle("perr_idle", 4 * Etu);
      check("perr_nack_len", nack_a_cycles, 16 * 8);
      step(2 * Etu);

      // Framing error only, then parity and framing together.
      send(8'h01, 1'b1, 1'b0, 12 * Etu, 1'b1);
      wait_idle("ferr_idle", 4 * Etu);
      check("ferr_data_hold", data_a, 8'h01);
      step(2 * Etu);
      send(8'h02, 1'b0, 1'b0, 12 * Etu, 1'b1);
      wait_idle("both_err_idle", 4 * Etu);
      step(2 * Etu);

      // Two-tick glitch: busy rises, then falls after the START decision.
      step(1);
      g0  = cyc;
      rxd = 1'b0;
      step(16);
      rxd = 1'b1;
      step(40 - 16);
      check("glitch_busy_high", busy_a, 1);
      wait_idle("glitch_rejected", 100);
      check("glitch_data_hold", data_a, 8'h02);
      step(2 * Etu);

      // Back-to-back good frames.
      send(8'hFF, 1'b0, 1'b1, 12 * Etu, 1'b1);
      send(8'h00, 1'b0, 1'b1, 12 * Etu, 1'b1);
      send(8'h80, 1'b1, 1'b1, 12 * Etu, 1'b1);
      wait_idle("b2b_idle", 4 * Etu);
      check("b2b_data_hold", data_a, 8'h80);
      step(2 * Etu);

      // Reset in the middle of data bit 4.
      send(8'h55, 1'b0, 1'b1, 5 * Etu + Etu / 2, 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_data", data_a, 8'h00);
      check("midrst_ready_flags", {ready_a, perr_a, ferr_a}, 0);
      check("midrst_nack_busy", {nack_a, busy_a, busy_b}, 0);
      step(4);
      rst = 1'b0;
      step(3 * Etu);
      send(8'h55, 1'b0, 1'b1, 12 * Etu, 1'b1);
      wait_idle("after_rst_idle", 4 * Etu);
      check("after_rst_data_hold", data_a, 8'h55);

      check("sb_a_drained", sb_a.size(), 0);
      check("sb_b_drained", sb_b.size(), 0);
      check("b_nack_never", nack_b_cycles, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
